// File: rtl/sm_line_pkg.sv
// Shared types and constants for the line detector.
package sm_line_pkg;

  localparam int FRAME_LEN = 48;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FOLLOW = 2'd1,
    NODE   = 2'd2,
    LOST   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    STOP     = 2'b00,
    LEFT     = 2'b01,
    RIGHT    = 2'b10,
    STRAIGHT = 2'b11
  } steer_t;

  // Pattern {left, centre, right} to steer; an all-white pattern keeps the last decision.
  function automatic steer_t steer_map(input logic [2:0] pat, input steer_t prev);
    steer_t s;
    s = prev;
    case (pat)
      3'b010, 3'b111, 3'b101: s = STRAIGHT;
      3'b100, 3'b110:         s = LEFT;
      3'b001, 3'b011:         s = RIGHT;
      default:                s = prev;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sm_line_avg.sv
// One sensor channel: optional 4-sample moving average.
// SM_LINE_AVG_EN defined: 4-deep history with running 14-bit sum, valid after 4 samples.
// SM_LINE_AVG_EN undefined: sample registered directly, valid after 1 sample.
module sm_line_avg (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en,
  input  logic [11:0] din,
  output logic [11:0] avg,
  output logic        valid
);

`ifdef SM_LINE_AVG_EN
  logic [11:0] hist [4];
  logic [13:0] sum;
  logic [2:0]  vcnt;

  // Shift the history and keep the sum exact by adding the new sample and dropping the oldest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      sum  <= '0;
      vcnt <= '0;
    end else if (sample_en) begin
      hist[0] <= din;
      for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
      sum <= sum + {2'b00, din} - {2'b00, hist[3]};
      if (vcnt != 3'd4) vcnt <= vcnt + 3'd1;
    end
  end

  assign avg   = sum[13:2];
  assign valid = vcnt[2];
`else
  // Bypass: hold the latest sample, valid from the first one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avg   <= '0;
      valid <= 1'b0;
    end else if (sample_en) begin
      avg   <= din;
      valid <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/sm_line_detector.sv
// Three-sensor line detector: frame timing, averaging, debounce and steering FSM.
// Averaging is compiled in only when SM_LINE_AVG_EN is defined.
//
// state  | meaning
// IDLE   | waiting for valid averages and a first debounced pattern
// FOLLOW | tracking the line, steering from the pattern
// NODE   | all three sensors black (junction)
// LOST   | pattern stayed white for LOST_FRAMES frames; steer STOP
module sm_line_detector
  import sm_line_pkg::*;
#(
  parameter logic [11:0] THRESHOLD   = 12'd1500,
  parameter int unsigned DEBOUNCE    = 3,
  parameter int unsigned LOST_FRAMES = 8
) (
  input  logic        adc_sck,
  input  logic        reset,
  input  logic [11:0] d_out_ch1,
  input  logic [11:0] d_out_ch3,
  input  logic [11:0] d_out_ch4,
  output logic [2:0]  line_pattern,
  output logic [1:0]  steer,
  output logic        node_pulse,
  output logic [3:0]  node_count,
  output logic        lost
);

  localparam logic [3:0] DB_MAX    = 4'(DEBOUNCE);
  localparam logic [7:0] LOST_MAX  = 8'(LOST_FRAMES);
  localparam logic [5:0] FRAME_END = 6'(FRAME_LEN - 1);

  logic [5:0]  frame_cnt;
  logic        frame_tick;
  logic [2:0]  tick_pipe;
  logic [11:0] avg_l, avg_c, avg_r;
  logic        val_l, val_c, val_r;
  logic        avg_valid;
  logic [2:0]  raw;
  logic [2:0]  prev_raw;
  logic [3:0]  db_cnt;
  logic        pattern_loaded;
  state_t      state, state_next;
  steer_t      steer_q, steer_next;
  logic [7:0]  lost_cnt, lost_cnt_next;
  logic        node_entry;

  assign frame_tick = (frame_cnt == FRAME_END);

  // Frame counter plus a delay line: tick_pipe[0] averages fresh, [1] debounce done, [2] pattern loaded.
  always_ff @(posedge adc_sck or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      tick_pipe <= '0;
    end else begin
      frame_cnt <= frame_tick ? 6'd0 : frame_cnt + 6'd1;
      tick_pipe <= {tick_pipe[1:0], frame_tick};
    end
  end

  sm_line_avg u_avg_l (.clk(adc_sck), .rst(reset), .sample_en(frame_tick), .din(d_out_ch1), .avg(avg_l), .valid(val_l));
  sm_line_avg u_avg_c (.clk(adc_sck), .rst(reset), .sample_en(frame_tick), .din(d_out_ch3), .avg(avg_c), .valid(val_c));
  sm_line_avg u_avg_r (.clk(adc_sck), .rst(reset), .sample_en(frame_tick), .din(d_out_ch4), .avg(avg_r), .valid(val_r));

  assign avg_valid = val_l & val_c & val_r;
  assign raw = {avg_l >= THRESHOLD, avg_c >= THRESHOLD, avg_r >= THRESHOLD};

  // Per-frame debounce; the stable pattern loads one cycle after the count reaches DEBOUNCE.
  always_ff @(posedge adc_sck or posedge reset) begin
    if (reset) begin
      prev_raw       <= '0;
      db_cnt         <= '0;
      line_pattern   <= '0;
      pattern_loaded <= 1'b0;
    end else begin
      if (tick_pipe[0] && avg_valid) begin
        prev_raw <= raw;
        if (raw != prev_raw)     db_cnt <= 4'd1;
        else if (db_cnt != DB_MAX) db_cnt <= db_cnt + 4'd1;
      end
      if (tick_pipe[1] && db_cnt == DB_MAX) begin
        line_pattern   <= prev_raw;
        pattern_loaded <= 1'b1;
      end
    end
  end

  // Next-state, steering and lost-frame counting, evaluated once per frame.
  always_comb begin
    state_next    = state;
    steer_next    = steer_q;
    lost_cnt_next = lost_cnt;
    node_entry    = 1'b0;
    if (tick_pipe[2]) begin
      if (line_pattern != 3'b000)
        lost_cnt_next = '0;
      else if (state == FOLLOW && lost_cnt != LOST_MAX)
        lost_cnt_next = lost_cnt + 8'd1;

      case (state)
        IDLE:   if (pattern_loaded) state_next = FOLLOW;
        FOLLOW: begin
          if (line_pattern == 3'b111)        state_next = NODE;
          else if (lost_cnt_next == LOST_MAX) state_next = LOST;
        end
        NODE:   if (line_pattern != 3'b111) state_next = FOLLOW;
        LOST: begin
          if (line_pattern == 3'b111)        state_next = NODE;
          else if (line_pattern != 3'b000)   state_next = FOLLOW;
        end
        default: state_next = IDLE;
      endcase

      node_entry = (state_next == NODE) && (state != NODE);
      if (state_next == FOLLOW || state_next == NODE)
        steer_next = steer_map(line_pattern, steer_q);
      else
        steer_next = STOP;
    end
  end

  // State and registered outputs.
  always_ff @(posedge adc_sck or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      steer_q    <= STOP;
      lost_cnt   <= '0;
      node_pulse <= 1'b0;
      node_count <= '0;
      lost       <= 1'b0;
    end else begin
      state      <= state_next;
      steer_q    <= steer_next;
      lost_cnt   <= lost_cnt_next;
      node_pulse <= node_entry;
      node_count <= node_count + {3'b000, node_entry};
      lost       <= (state_next == LOST);
    end
  end

  assign steer = steer_q;

endmodule

// File: tb/tb_sm_line_detector.sv
// Directed bench for sm_line_detector; expected timing follows the SM_LINE_AVG_EN setting.
`timescale 1ns/1ps
module tb_sm_line_detector;

`ifdef SM_LINE_AVG_EN
  localparam int AVG_N = 4;
`else
  localparam int AVG_N = 1;
`endif
  localparam int LOAD_FRAMES = AVG_N + 2;  // first debounced pattern, DEBOUNCE=3
  localparam int FR = 48;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] ch1 = '0, ch3 = '0, ch4 = '0;
  logic [2:0]  line_pattern;
  logic [1:0]  steer;
  logic        node_pulse;
  logic [3:0]  node_count;
  logic        lost;

  int total = 0;
  int bad   = 0;
  int pulse_cnt = 0;
  logic prev_pulse = 1'b0;
  logic wide_seen = 1'b0;
  logic flip_mon = 1'b0;
  logic seen_100 = 1'b0;
  logic bad_steer = 1'b0;

  sm_line_detector dut (
    .adc_sck(clk), .reset(rst),
    .d_out_ch1(ch1), .d_out_ch3(ch3), .d_out_ch4(ch4),
    .line_pattern(line_pattern), .steer(steer), .node_pulse(node_pulse),
    .node_count(node_count), .lost(lost)
  );

  always #160 clk = ~clk;

  always @(negedge clk) begin
    if (node_pulse) begin
      pulse_cnt++;
      if (prev_pulse) wide_seen = 1'b1;
    end
    prev_pulse = node_pulse;
    if (flip_mon) begin
      if (line_pattern == 3'b100) seen_100 = 1'b1;
      if (steer != 2'b11) bad_steer = 1'b1;
    end
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
    ch1 = a; ch3 = b; ch4 = c;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_lp(input logic [2:0] want, input int max_cyc, input string tag);
    int n = 0;
    while (line_pattern != want && n < max_cyc) begin
      step(1);
      n++;
    end
    check_val(tag, int'(line_pattern), int'(want));
  endtask

  task automatic wait_pulse(input int max_cyc, input string tag);
    int n = 0;
    while (!node_pulse && n < max_cyc) begin
      step(1);
      n++;
    end
    check_val(tag, int'(node_pulse), 1);
  endtask

  // Releases reset just after an edge and checks the exact first-load frame.
  task automatic startup_check(input string tag);
    @(posedge clk); #1;
    rst = 1'b0;
    step(FR * (LOAD_FRAMES - 1) + 10);
    check_val({tag, "_pre_load_pattern"}, int'(line_pattern), 0);
    check_val({tag, "_pre_load_steer"}, int'(steer), 0);
    step(FR);
    check_val({tag, "_load_pattern"}, int'(line_pattern), 3'b010);
    check_val({tag, "_follow_steer"}, int'(steer), 2'b11);
    check_val({tag, "_not_lost"}, int'(lost), 0);
  endtask

  initial begin
    set_ch(12'd200, 12'd3000, 12'd200);
    rst = 1'b1;
    #1;
    check_val("rst_pattern", int'(line_pattern), 0);
    check_val("rst_steer", int'(steer), 0);
    check_val("rst_pulse", int'(node_pulse), 0);
    check_val("rst_count", int'(node_count), 0);
    check_val("rst_lost", int'(lost), 0);
    step(3);
    startup_check("start");

    // Two-frame glitch towards the left must be filtered.
    flip_mon = 1'b1;
    set_ch(12'd3000, 12'd200, 12'd200);
    step(2 * FR);
    set_ch(12'd200, 12'd3000, 12'd200);
    step(8 * FR);
    flip_mon = 1'b0;
    check_val("glitch_no_100", int'(seen_100), 0);
    check_val("glitch_steer_held", int'(bad_steer), 0);
    check_val("glitch_pattern", int'(line_pattern), 3'b010);

    // Junction.
    set_ch(12'd3500, 12'd3500, 12'd3500);
    step(10 * FR);
    check_val("node_pulses", pulse_cnt, 1);
    check_val("node_count_one", int'(node_count), 1);
    check_val("node_pattern", int'(line_pattern), 3'b111);
    check_val("node_steer", int'(steer), 2'b11);
    set_ch(12'd200, 12'd3000, 12'd200);
    step(10 * FR);
    check_val("node_exit_pattern", int'(line_pattern), 3'b010);
    check_val("node_exit_no_pulse", pulse_cnt, 1);
    check_val("node_exit_steer", int'(steer), 2'b11);

    // Losing the line: 8 frames of 000 from the pattern load.
    set_ch(12'd100, 12'd100, 12'd100);
    wait_lp(3'b000, 20 * FR, "lost_pattern_zero");
    check_val("lost_steer_hold", int'(steer), 2'b11);
    step(7 * FR);
    check_val("lost_not_yet", int'(lost), 0);
    step(1);
    check_val("lost_set", int'(lost), 1);
    check_val("lost_steer_stop", int'(steer), 0);

    set_ch(12'd100, 12'd100, 12'd3000);
    wait_lp(3'b001, 20 * FR, "recover_pattern");
    step(1);
    check_val("recover_steer_right", int'(steer), 2'b10);
    check_val("recover_lost_clear", int'(lost), 0);

    // Threshold boundary: 1500 black, 1499 white.
    set_ch(12'd1500, 12'd1499, 12'd1500);
    wait_lp(3'b101, 20 * FR, "thresh_101");
    step(1);
    check_val("thresh_101_steer", int'(steer), 2'b11);
    set_ch(12'd1499, 12'd1500, 12'd1499);
    wait_lp(3'b010, 20 * FR, "thresh_010");
    step(1);
    check_val("thresh_010_steer", int'(steer), 2'b11);
    check_val("thresh_not_lost", int'(lost), 0);

    // Fifteen more junctions wrap the count back to 0.
    for (int i = 0; i < 15; i++) begin
      set_ch(12'd3500, 12'd3500, 12'd3500);
      wait_pulse(20 * FR, "wrap_pulse");
      set_ch(12'd200, 12'd3000, 12'd200);
      wait_lp(3'b010, 20 * FR, "wrap_back");
      if (i == 0) check_val("wrap_count_two", int'(node_count), 2);
    end
    step(1);
    check_val("wrap_count_zero", int'(node_count), 0);
    check_val("wrap_total_pulses", pulse_cnt, 16);
    check_val("pulse_width_one", int'(wide_seen), 0);

    // Reset at frame count 20 while in NODE.
    set_ch(12'd3500, 12'd3500, 12'd3500);
    wait_pulse(20 * FR, "pre_reset_pulse");
    check_val("pre_reset_count", int'(node_count), 1);
    step(17);
    rst = 1'b1;
    #1;
    check_val("midrst_pattern", int'(line_pattern), 0);
    check_val("midrst_steer", int'(steer), 0);
    check_val("midrst_pulse", int'(node_pulse), 0);
    check_val("midrst_count", int'(node_count), 0);
    check_val("midrst_lost", int'(lost), 0);
    set_ch(12'd200, 12'd3000, 12'd200);
    step(3);
    startup_check("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
